// File: rtl/sevseg_source_arbiter_if.sv
// Bundle of request and display signals between the hex-value requesters
// and the seven-segment source arbiter.
interface sevseg_source_arbiter_if #(
    parameter int N_REQ = 3
) ();
    logic [N_REQ-1:0]    req;
    logic [32*N_REQ-1:0] val_i;
    logic [31:0]         default_val;
    logic [31:0]         hex_val;
    logic [N_REQ-1:0]    grant;
    logic [1:0]          src_id;
    logic                busy;

    modport master (
        output req, val_i, default_val,
        input  hex_val, grant, src_id, busy
    );

    modport slave (
        input  req, val_i, default_val,
        output hex_val, grant, src_id, busy
    );
endinterface

// File: rtl/sevseg_source_arbiter.sv
// Round-robin time-sharing of the 8-digit hex display between N_REQ
// requesters and a live default source. Each award holds the display for
// HOLD_CYCLES clocks. All outputs are registered.
module sevseg_source_arbiter #(
    parameter int N_REQ       = 3,
    parameter int HOLD_CYCLES = 5_000_000
) (
    input  logic                   clk_5mhz0d,
    input  logic                   rst_n,
    sevseg_source_arbiter_if.slave bus
);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

    // Request synchronizer and edge detect
    logic [N_REQ-1:0]        req_meta_reg;
    logic [N_REQ-1:0]        req_s_reg;
    logic [N_REQ-1:0]        req_s_d_reg;
    logic [N_REQ-1:0]        req_rise;

    // Values travel through the same two-stage pipe as their request so a
    // value and its req_s level are always seen together.
    logic [N_REQ-1:0][31:0]  val_meta_reg;
    logic [N_REQ-1:0][31:0]  val_s_reg;

    logic [N_REQ-1:0]        pending_reg;
    logic [N_REQ-1:0]        pending_next;
    logic [1:0]              rr_ptr_reg;
    logic [CNT_W-1:0]        hold_cnt_reg;
    logic [0:0]              state_reg;
    logic [1:0]              src_reg;

    logic [31:0]             hex_val_reg;
    logic [N_REQ-1:0]        grant_reg;
    logic                    busy_reg;

    // Arbitration results
    logic                    winner_found;
    logic [1:0]              winner_idx;
    logic [N_REQ-1:0]        winner_onehot;
    logic [1:0]              rr_ptr_next;
    logic [31:0]             winner_val;
    logic [31:0]             src_val;
    logic                    src_req_s;
    logic                    hold_done;
    logic                    award;

    assign req_rise  = req_s_reg & ~req_s_d_reg;
    assign hold_done = (hold_cnt_reg == HOLD_LAST);

    // Award happens from IDLE as soon as anything is pending, or at the end
    // of a hold when something is pending (back-to-back, no IDLE gap).
    assign award = winner_found && ((state_reg == ST_IDLE) || hold_done);

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign winner_onehot[gi] = (winner_idx == 2'(gi));
        end
    endgenerate

    // Two-flop synchronizer on req (and the matching value pipe), then a
    // registered copy of req_s for rising-edge detection.
    always_ff @(posedge clk_5mhz0d) begin
        if (!rst_n) begin
            req_meta_reg <= '0;
            req_s_reg    <= '0;
            req_s_d_reg  <= '0;
            val_meta_reg <= '0;
            val_s_reg    <= '0;
        end else begin
            req_meta_reg <= bus.req;
            req_s_reg    <= req_meta_reg;
            req_s_d_reg  <= req_s_reg;
            val_meta_reg <= bus.val_i;
            val_s_reg    <= val_meta_reg;
        end
    end

    // Round-robin search: first pending bit at or above rr_ptr, wrapping.
    always_comb begin
        winner_found = 1'b0;
        winner_idx   = 2'd0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!winner_found && pending_reg[j] &&
                    (j == ((int'(rr_ptr_reg) + i) % N_REQ))) begin
                    winner_found = 1'b1;
                    winner_idx   = 2'(j);
                end
            end
        end
        rr_ptr_next = 2'((int'(winner_idx) + 1) % N_REQ);
    end

    // Select the winner's value for an award and the current source's
    // value/level for live refresh during SHOW.
    always_comb begin
        winner_val = '0;
        src_val    = '0;
        src_req_s  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (winner_idx == 2'(k)) begin
                winner_val = val_s_reg[k];
            end
            if (src_reg == 2'(k)) begin
                src_val   = val_s_reg[k];
                src_req_s = req_s_reg[k];
            end
        end
    end

    // New edges set pending; an award clears its bit, overriding a
    // same-cycle edge on that bit.
    always_comb begin
        pending_next = pending_reg | req_rise;
        if (award) begin
            pending_next = pending_next & ~winner_onehot;
        end
    end

    // Display FSM: IDLE shows default_val live, SHOW holds one requester
    // for HOLD_CYCLES, refreshing its value while its request stays high.
    always_ff @(posedge clk_5mhz0d) begin
        if (!rst_n) begin
            pending_reg  <= '0;
            rr_ptr_reg   <= 2'd0;
            hold_cnt_reg <= '0;
            state_reg    <= ST_IDLE;
            src_reg      <= 2'd0;
            hex_val_reg  <= 32'd0;
            grant_reg    <= '0;
            busy_reg     <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            if (award) begin
                state_reg    <= ST_SHOW;
                src_reg      <= winner_idx;
                grant_reg    <= winner_onehot;
                rr_ptr_reg   <= rr_ptr_next;
                hold_cnt_reg <= '0;
                busy_reg     <= 1'b1;
                hex_val_reg  <= winner_val;
            end else if (state_reg == ST_IDLE || hold_done) begin
                state_reg    <= ST_IDLE;
                src_reg      <= 2'd0;
                grant_reg    <= '0;
                hold_cnt_reg <= '0;
                busy_reg     <= 1'b0;
                hex_val_reg  <= bus.default_val;
            end else begin
                hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
                if (src_req_s) begin
                    hex_val_reg <= src_val;
                end
            end
        end
    end

    assign bus.hex_val = hex_val_reg;
    assign bus.grant   = grant_reg;
    assign bus.src_id  = src_reg;
    assign bus.busy    = busy_reg;

endmodule
